// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the arbitrated UART transmitter.
package uart_pkg;
    localparam int N_REQ    = 4;
    localparam int DEF_FREQ = 12000000;
    localparam int DEF_BAUD = 9600;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;
endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer: one start pulse launches a frame of the byte on data, LSB first.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic          tx_q, tx_d;
    logic          bit_end;
    logic [2:0]    idx_nxt;

    assign bit_end = (timer_q == LAST);
    assign idx_nxt = idx_q + 3'd1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                if (start) begin
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    timer_d = '0;
                    idx_d   = '0;
                    tx_d    = data[0];
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                // tx_d is the value for the next cycle, so the next bit is loaded at the boundary
                if (bit_end) begin
                    timer_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_nxt;
                        tx_d  = data[idx_nxt];
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    timer_d = '0;
                    tx_d    = 1'b1;
                    done    = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    assign tx = tx_q;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from N_REQ byte requesters.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int FREQ         = DEF_FREQ,
    parameter int BAUD         = DEF_BAUD,
    parameter int CLKS_PER_BIT = FREQ / BAUD
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx,
    output logic               busy,
    output logic [1:0]         grant_id
);
    logic             busy_q, busy_d;
    logic [N_REQ-1:0] ready_q, ready_d;
    logic [1:0]       grant_id_q, grant_id_d;
    logic [1:0]       last_grant_q, last_grant_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       pick, cand;
    logic             found;
    logic             core_done;

    // Search starts just past the last grant; the last grantee is checked last.
    always_comb begin
        found = 1'b0;
        pick  = last_grant_q;
        cand  = last_grant_q;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = last_grant_q + 2'(k);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        busy_d       = busy_q;
        ready_d      = '0;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        if (!busy_q && found) begin
            busy_d       = 1'b1;
            ready_d      = N_REQ'(1) << pick;
            grant_id_d   = pick;
            last_grant_d = pick;
            data_d       = req_data[{pick, 3'b000} +: 8];
        end else if (core_done) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            busy_q       <= 1'b0;
            ready_q      <= '0;
            grant_id_q   <= 2'd0;
            last_grant_q <= 2'd3;
            data_q       <= '0;
        end else begin
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
        end
    end

    // The ready pulse doubles as the core start strobe; data_q is already loaded then.
    uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
        .clk   (clk),
        .nrst  (nrst),
        .start (|ready_q),
        .data  (data_q),
        .tx    (tx),
        .done  (core_done)
    );

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of the arbitrated UART transmitter against a frame-level model.
module tb_uart_tx_arbiter;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        tx, busy;
    logic [1:0]  grant_id;

    logic [3:0]  d_req_valid = '0;
    logic [31:0] d_req_data = '0;
    logic [3:0]  d_req_ready;
    logic        d_tx, d_busy;
    logic [1:0]  d_grant_id;

    int total = 0;
    int bad = 0;

    int         lg;
    logic [3:0] pend;
    logic [7:0] bytes [4];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.CLKS_PER_BIT(CPB)) u_dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id)
    );

    uart_tx_arbiter u_def (
        .clk(clk), .nrst(nrst), .req_valid(d_req_valid), .req_data(d_req_data),
        .req_ready(d_req_ready), .tx(d_tx), .busy(d_busy), .grant_id(d_grant_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin: first pending requester after the last grant, wrapping.
    function automatic int rr_next();
        for (int k = 1; k <= 4; k++) begin
            if (pend[(lg + k) % 4]) return (lg + k) % 4;
        end
        return -1;
    endfunction

    task automatic set_req(input int id, input logic [7:0] b);
        bytes[id] = b;
        pend[id] = 1'b1;
        req_valid[id] = 1'b1;
        req_data[8*id +: 8] = b;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        req_valid = '0;
        pend = '0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        lg = 3;
        @(negedge clk);
    endtask

    // Expects a grant to id, then the whole 8N1 frame of b, one CPB-cycle slot per bit.
    task automatic run_frame(input int id, input logic [7:0] b, input bit sticky, input bit corrupt);
        int n;
        logic exp_tx;
        n = 0;
        while (req_ready == 4'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            chk("ready_timeout", 32'(req_ready), 32'(4'b1 << id));
            return;
        end
        chk("ready_onehot", 32'(req_ready), 32'(4'b1 << id));
        chk("grant_id", 32'(grant_id), 32'(id));
        chk("busy_capture", 32'(busy), 32'd1);
        if (!sticky) begin
            req_valid[id] = 1'b0;
            pend[id] = 1'b0;
        end
        lg = id;
        for (int c = 0; c < 10 * CPB; c++) begin
            @(negedge clk);
            if (corrupt && c == 8) req_data[8*id +: 8] = 8'hFF;
            if (c < CPB) exp_tx = 1'b0;
            else if (c < 9 * CPB) exp_tx = b[c / CPB - 1];
            else exp_tx = 1'b1;
            chk($sformatf("tx_c%0d", c), 32'(tx), 32'(exp_tx));
            chk("busy_frame", 32'(busy), 32'd1);
            chk("ready_quiet", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        chk("busy_end", 32'(busy), 32'd0);
        chk("tx_idle_end", 32'(tx), 32'd1);
    endtask

    initial begin
        int id, lo, hi, glitch, n;
        lg = 3;
        pend = '0;
        for (int i = 0; i < 4; i++) bytes[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_tx", 32'(tx), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single request, byte 0x54
        set_req(0, 8'h54);
        run_frame(0, 8'h54, 1'b0, 1'b0);

        // All four at once from reset: order 0,1,2,3
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8'hA0 + 8'(i));
        for (int f = 0; f < 4; f++) begin
            id = rr_next();
            run_frame(id, bytes[id], 1'b0, 1'b0);
        end

        // Requesters 1 and 3 held continuously: alternate
        do_reset();
        set_req(1, 8'h3C);
        set_req(3, 8'hC5);
        for (int f = 0; f < 4; f++) begin
            id = rr_next();
            run_frame(id, bytes[id], 1'b1, 1'b0);
        end
        req_valid = '0;
        pend = '0;

        // Data changed mid-frame
        set_req(2, 8'h55);
        run_frame(2, 8'h55, 1'b0, 1'b1);

        // Reset during DATA bit 3
        set_req(1, 8'h96);
        n = 0;
        while (req_ready == 4'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("abort_ready", 32'(req_ready), 32'h2);
        repeat (4 * CPB + 2) @(negedge clk);
        chk("abort_bit3", 32'(tx), 32'(bytes[1][3]));
        nrst = 1'b0;
        req_valid = '0;
        pend = '0;
        @(negedge clk);
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_grant", 32'(grant_id), 32'd0);
        nrst = 1'b1;
        lg = 3;
        repeat (2 * CPB) @(negedge clk);
        chk("abort_no_retx", 32'(tx), 32'd1);
        for (int i = 0; i < 4; i++) set_req(i, 8'($urandom));
        while (pend != 4'b0) begin
            id = rr_next();
            run_frame(id, bytes[id], 1'b0, 1'b0);
        end

        // Randomized arrivals and withdrawals
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(1) == 1) set_req(i, 8'($urandom));
                else if (pend[i] && $urandom_range(7) == 0) begin
                    pend[i] = 1'b0;
                    req_valid[i] = 1'b0;
                end
            end
            if (pend == 4'b0) begin
                @(negedge clk);
                chk("rand_idle_busy", 32'(busy), 32'd0);
                continue;
            end
            id = rr_next();
            run_frame(id, bytes[id], 1'b0, 1'b0);
        end
        req_valid = '0;
        pend = '0;

        // Default parameters, byte 0x00
        d_req_data = '0;
        d_req_valid = 4'b0001;
        n = 0;
        while (d_req_ready == 4'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("def_ready", 32'(d_req_ready), 32'h1);
        d_req_valid = '0;
        lo = 0;
        hi = 0;
        glitch = 0;
        for (int c = 0; c < 13000; c++) begin
            @(negedge clk);
            if (!d_busy) break;
            if (d_tx == 1'b0 && hi == 0) lo++;
            else if (d_tx == 1'b1) hi++;
            else glitch++;
        end
        chk("def_low", 32'(lo), 32'd11250);
        chk("def_high", 32'(hi), 32'd1250);
        chk("def_glitch", 32'(glitch), 32'd0);
        chk("def_idle", 32'(d_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter FREQ, default 12000000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600: serial bit rate.
REQ-003 Parameter CLKS_PER_BIT, default FREQ/BAUD (1250): clock cycles per serial bit; integer division, minimum value 2.
REQ-004 clk  in  1  system clock; all logic rising-edge.
REQ-005 nrst  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  4  per-requester byte-pending flag; bit i belongs to requester i.
REQ-007 req_data  in  32  requester i byte on bits [8i+7:8i].
REQ-008 req_ready  out  4  one-cycle pulse on bit i when requester i byte is captured.
REQ-009 tx  out  1  serial line; idle high; 8N1 framing; data sent LSB first.
REQ-010 busy  out  1  high from the capture cycle through the last cycle of the stop bit.
REQ-011 grant_id  out  2  index of the requester that owns the current frame; holds its value when idle.

Function
REQ-012 The FSM shall have states IDLE, START, DATA, and STOP.
REQ-013 IDLE: if any req_valid bit is high, grant one requester that cycle, pulse its req_ready, capture its byte, set grant_id, and move to START; otherwise stay in IDLE with tx=1.
REQ-014 Arbitration shall be round-robin: search starts at (last_grant+1) mod 4 and wraps; after reset, last_grant=3, so requester 0 has first priority.
REQ-015 At most one req_ready bit shall be high in any cycle, and only in an IDLE capture cycle.
REQ-016 START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-017 DATA: tx=byte[k] for k=0..7, each held exactly CLKS_PER_BIT cycles; a 3-bit index and the bit timer shall advance together; after k=7, go to STOP.
REQ-018 STOP: tx=1 for exactly CLKS_PER_BIT cycles, then go to IDLE.
REQ-019 A frame shall last 10*CLKS_PER_BIT cycles from the first START cycle; the next START shall come no earlier than 1 IDLE cycle after STOP ends.
REQ-020 The bit timer shall count 0..CLKS_PER_BIT-1, be $clog2(CLKS_PER_BIT) bits wide, and wrap to 0 at every bit boundary with no extra cycle.
REQ-021 The captured byte shall be registered; changes to req_data or req_valid after capture shall not affect the frame in flight.
REQ-022 A requester that drops req_valid before being granted shall lose its turn, with no error flagged.
REQ-023 A requester holding req_valid across frames shall be regranted only after all other active requesters have been served.
REQ-024 tx shall be registered, with no combinational path from any input to tx.

Reset
REQ-025 When nrst=0 at a clock edge: state=IDLE, tx=1, busy=0, req_ready=0, grant_id=0, last_grant=3, and the bit timer and bit index cleared.
REQ-026 Reset mid-frame shall abort the frame; tx=1 from the next edge, and the captured byte shall be discarded, not retransmitted.

Structure
REQ-027 Package uart_pkg shall hold N_REQ=4, the default FREQ/BAUD values, and the FSM state encoding (2-bit).
REQ-028 Serialization shall live in sub-module uart_tx_core (inputs start and data[7:0]; outputs tx and done; contains the bit timer, bit index, and START/DATA/STOP states).
REQ-029 uart_tx_arbiter shall contain the round-robin grant logic, the capture register, and the busy/grant_id outputs.

Verification
REQ-030 Single request: CLKS_PER_BIT=4, req_valid=0001, byte 0x54 -> req_ready[0] pulses once; tx=0, then 0,0,1,0,1,0,1,0, then 1, each 4 cycles; busy high 41 cycles.
REQ-031 All four requesters valid at once with bytes 0xA0..0xA3 -> frames sent in order 0,1,2,3; grant_id matches each frame.
REQ-032 Requesters 1 and 3 valid continuously -> grants alternate 1,3,1,3; requester 1 is never granted twice in a row.
REQ-033 req_data changed mid-frame from 0x55 to 0xFF -> the line still carries 0x55.
REQ-034 nrst pulsed low during DATA bit 3 -> tx=1 next cycle, busy=0, and the next grant goes to requester 0.
REQ-035 Default parameters with byte 0x00 -> tx low for exactly 11250 cycles, then high for 1250.
